// File: rtl/serial_paralelo_align_pkg.sv
// Shared constants and state encoding for the serial-to-parallel byte aligner.
package serial_paralelo_align_pkg;

    localparam int BYTE_W = 8;

    // Idle/alignment character used to find byte boundaries.
    localparam logic [BYTE_W-1:0] COM_BYTE_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        ALIGNING = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    // The last bit of a byte lands when the bit counter reads 7.
    function automatic logic is_boundary(input logic [2:0] cnt);
        return cnt == 3'd7;
    endfunction

endpackage

// File: rtl/serial_paralelo_align_byte_shift_reg.sv
// Serial history register; win is the byte completed by the bit arriving this edge.
module byte_shift_reg
    import serial_paralelo_align_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              serial_in,
    output logic [BYTE_W-1:0] win
);

    // Only the seven most recent bits are stored: the oldest bit of an
    // eight-bit register would never be read, because win already
    // appends the incoming bit combinationally.
    logic [BYTE_W-2:0] hist_reg;

    assign win[0] = serial_in;

    genvar gi;
    generate
        for (gi = 1; gi < BYTE_W; gi++) begin : g_win
            assign win[gi] = hist_reg[gi-1];
        end
    endgenerate

    // Shift in one bit per clock, MSB-first; reset discards the incoming bit.
    always_ff @(posedge clk) begin
        if (srst) begin
            hist_reg <= '0;
        end else begin
            hist_reg <= win[BYTE_W-2:0];
        end
    end

endmodule

// File: rtl/serial_paralelo_align.sv
// Bit-serial receiver front end: finds byte alignment on a run of COM
// characters, then emits every completed byte with a valid flag and strobe.
module serial_paralelo_align
    import serial_paralelo_align_pkg::*;
#(
    parameter logic [7:0] COM_BYTE   = COM_BYTE_DEFAULT,
    parameter int         LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    // com_cnt value that, with one more aligned COM byte, completes lock.
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);

    logic [BYTE_W-1:0] win;
    logic              is_com;
    logic              boundary;

    state_t            state_reg, state_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [3:0]        com_cnt_reg, com_cnt_next;
    logic [7:0]        data_reg, data_next;
    logic              valid_reg, valid_next;
    logic              strobe_reg, strobe_next;
    logic              active_reg, active_next;

    byte_shift_reg u_shift (
        .clk       (clk_32f),
        .srst      (reset),
        .serial_in (serial_in),
        .win       (win)
    );

    assign is_com   = (win == COM_BYTE);
    assign boundary = is_boundary(bit_cnt_reg);

    // State, counters and registered outputs; reset clears everything.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_reg   <= SEARCH;
            bit_cnt_reg <= '0;
            com_cnt_reg <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            strobe_reg  <= 1'b0;
            active_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            com_cnt_reg <= com_cnt_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            strobe_reg  <= strobe_next;
            active_reg  <= active_next;
        end
    end

    // Alignment FSM: slide in SEARCH, verify whole COM bytes in ALIGNING,
    // then publish each byte at its boundary once LOCKED (lock never drops).
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg + 3'd1;
        com_cnt_next = com_cnt_reg;
        data_next    = data_reg;
        valid_next   = valid_reg;
        strobe_next  = 1'b0;
        active_next  = active_reg;

        unique case (state_reg)
            SEARCH: begin
                if (is_com) begin
                    bit_cnt_next = '0;
                    com_cnt_next = 4'd1;
                    if (LOCK_COUNT == 1) begin
                        state_next  = LOCKED;
                        active_next = 1'b1;
                    end else begin
                        state_next = ALIGNING;
                    end
                end
            end
            ALIGNING: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_next = com_cnt_reg + 4'd1;
                        if (com_cnt_reg == LOCK_LAST) begin
                            state_next  = LOCKED;
                            active_next = 1'b1;
                        end
                    end else begin
                        com_cnt_next = '0;
                        state_next   = SEARCH;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    data_next   = win;
                    valid_next  = !is_com;
                    strobe_next = 1'b1;
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    assign data_out    = data_reg;
    assign valid_out   = valid_reg;
    assign byte_strobe = strobe_reg;
    assign active      = active_reg;

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Randomised scoreboard bench for serial_paralelo_align.
module tb_serial_paralelo_align;

    localparam logic [7:0] COM   = 8'hBC;
    localparam int         LOCKN = 4;

    logic       clk_32f   = 1'b0;
    logic       reset     = 1'b1;
    logic       serial_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    serial_paralelo_align #(
        .COM_BYTE   (COM),
        .LOCK_COUNT (LOCKN)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk_32f = ~clk_32f;

    // Per-cycle expectation and per-output-byte expectation.
    typedef struct packed {
        logic rst;
        logic act;
        logic stb;
    } cyc_t;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } byte_t;

    cyc_t  cyc_q[$];
    byte_t byte_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model: the bit stream since the last reset, plus the index of
    // the last bit of a candidate COM run and of the locking COM byte.
    logic bits_q[$];
    int   cand_end = -1;
    int   runs     = 0;
    int   lock_end = -1;

    function automatic logic [7:0] model_window();
        logic [7:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = bits_q.size() - 8 + k;
            if (idx >= 0) w[7-k] = bits_q[idx];
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_32f);
            reset     = 1'b1;
            serial_in = 1'($urandom);
            bits_q.delete();
            cand_end = -1;
            runs     = 0;
            lock_end = -1;
            cyc_q.push_back('{rst: 1'b1, act: 1'b0, stb: 1'b0});
        end
    endtask

    task automatic send_bit(input logic b);
        logic [7:0] w;
        logic       stb;
        int         n;
        @(negedge clk_32f);
        reset     = 1'b0;
        serial_in = b;
        bits_q.push_back(b);
        n   = bits_q.size() - 1;
        w   = model_window();
        stb = 1'b0;
        if (lock_end >= 0) begin
            if ((n - lock_end) % 8 == 0) begin
                stb = 1'b1;
                byte_q.push_back('{d: w, v: (w != COM)});
            end
        end else if (cand_end < 0) begin
            if (w == COM) begin
                cand_end = n;
                runs     = 1;
                if (runs == LOCKN) lock_end = n;
            end
        end else if ((n - cand_end) % 8 == 0) begin
            if (w == COM) begin
                runs++;
                if (runs == LOCKN) lock_end = n;
            end else begin
                cand_end = -1;
            end
        end
        cyc_q.push_back('{rst: 1'b0, act: (lock_end >= 0), stb: stb});
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_coms(input int cnt);
        for (int i = 0; i < cnt; i++) send_byte(COM);
    endtask

    // Monitor: one expectation per clock, byte expectations popped on strobe.
    logic [7:0] last_d = '0;
    logic       last_v = 1'b0;

    initial begin
        cyc_t  e;
        byte_t bx;
        forever begin
            @(posedge clk_32f);
            #1;
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                if (e.rst) begin
                    last_d = '0;
                    last_v = 1'b0;
                end
                check("active", 32'(active), 32'(e.act));
                check("byte_strobe", 32'(byte_strobe), 32'(e.stb));
                if (byte_strobe) begin
                    if (byte_q.size() == 0) begin
                        check("unexpected_strobe", 32'(byte_strobe), 32'd0);
                    end else begin
                        bx = byte_q.pop_front();
                        last_d = bx.d;
                        last_v = bx.v;
                        $display("byte data_out=0x%02h valid_out=%0b at %0t", data_out, valid_out, $time);
                    end
                end
                check("data_out", 32'(data_out), 32'(last_d));
                check("valid_out", 32'(valid_out), 32'(last_v));
            end
        end
    end

    initial begin
        // Reset held with toggling input, then lock after garbage bits.
        do_reset(2);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_coms(4);
        send_byte(8'hA5);
        // Locked: COM byte reported as non-valid, then payload.
        send_byte(COM);
        send_byte(8'h3C);
        // COM pattern straddling a boundary must not realign.
        send_byte(8'h0B);
        send_byte(8'hC0);
        send_byte(8'h5A);
        // Reset mid-byte, payload ignored, broken run, then relock.
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        do_reset(1);
        send_byte(8'hA5);
        send_coms(3);
        send_byte(8'h11);
        send_coms(4);
        send_byte(8'h77);
        send_byte(8'hE1);

        // Randomised segments.
        for (int it = 0; it < 40; it++) begin
            int nb;
            do_reset(1 + int'($urandom_range(0, 1)));
            nb = int'($urandom_range(0, 7));
            for (int i = 0; i < nb; i++) send_bit(1'($urandom));
            if ($urandom_range(0, 3) != 0) send_coms(LOCKN);
            for (int i = 0; i < 12; i++) begin
                if ($urandom_range(0, 2) == 0) send_byte(COM);
                else send_byte(8'($urandom));
            end
            nb = int'($urandom_range(0, 7));
            for (int i = 0; i < nb; i++) send_bit(1'($urandom));
        end

        repeat (3) @(negedge clk_32f);
        check("pending_cycles", 32'(cyc_q.size()), 32'd0);
        check("pending_bytes", 32'(byte_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
